// File: rtl/conv_tile_sched_if.sv
// Command handshake bundle between the layer sequencer/host (master) and conv_tile_sched (slave).
interface conv_tile_sched_if #(
  parameter int IFM_AW = 12,
  parameter int WGT_AW = 10,
  parameter int OFM_AW = 12,
  parameter int TILE_W = 4
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [TILE_W-1:0] cmd_tiles;
  logic [1:0]        cmd_ci;
  logic [1:0]        cmd_co;
  logic [IFM_AW-1:0] cmd_ifm_base;
  logic [WGT_AW-1:0] cmd_wgt_base;
  logic [OFM_AW-1:0] cmd_ofm_base;

  modport master (
    output cmd_valid, cmd_tiles, cmd_ci, cmd_co, cmd_ifm_base, cmd_wgt_base, cmd_ofm_base,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_tiles, cmd_ci, cmd_co, cmd_ifm_base, cmd_wgt_base, cmd_ofm_base,
    output cmd_ready
  );
endinterface

// File: rtl/conv_tile_sched.sv
// Tile scheduler for the 3x3 conv accelerator: per-tile start/end sequencing plus SRAM address generation.
// Optional SCHED_PERF_EN adds a saturating RUN-cycle counter on perf_cycles.
//
// state | meaning
// IDLE  | waiting for a command, cmd_ready high
// LOAD  | command latched, pointers loaded, tile count validated
// START | acc_start pulse, weight pointer and watchdog rewound
// RUN   | accelerator active, strobes mapped to SRAM accesses
// DONE  | done pulse, err reports illegal command or timeout
module conv_tile_sched #(
  parameter int IFM_AW = 12,
  parameter int WGT_AW = 10,
  parameter int OFM_AW = 12,
  parameter int TILE_W = 4,
  parameter int TO_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  conv_tile_sched_if.slave  cmd,
  output logic              acc_start,
  output logic [1:0]        acc_cfg_ci,
  output logic [1:0]        acc_cfg_co,
  input  logic              acc_ifm_read,
  input  logic              acc_wgt_read,
  input  logic              acc_ofm0_v,
  input  logic              acc_ofm1_v,
  input  logic              acc_end,
  output logic              ifm_ren,
  output logic [IFM_AW-1:0] ifm_addr,
  output logic              wgt_ren,
  output logic [WGT_AW-1:0] wgt_addr,
  output logic              ofm_we0,
  output logic [OFM_AW-1:0] ofm_addr0,
  output logic              ofm_we1,
  output logic [OFM_AW-1:0] ofm_addr1,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [TILE_W-1:0] tile_idx
`ifdef SCHED_PERF_EN
  ,
  output logic [31:0]       perf_cycles
`endif
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_START, S_RUN, S_DONE} state_t;

  localparam logic [TO_W-1:0] WD_MAX = '1;

  state_t            state;
  logic [TILE_W-1:0] tiles_q;
  logic [IFM_AW-1:0] ifm_base_q;
  logic [WGT_AW-1:0] wgt_base_q;
  logic [OFM_AW-1:0] ofm_base_q;
  logic [IFM_AW-1:0] ifm_ptr;
  logic [WGT_AW-1:0] wgt_ptr;
  logic [OFM_AW-1:0] ofm_ptr;
  logic [TO_W-1:0]   wd_cnt;
  logic              run;
  logic [1:0]        ofm_inc;

  assign run       = (state == S_RUN);
  assign ifm_ren   = run & acc_ifm_read;
  assign ifm_addr  = ifm_ptr;
  assign wgt_ren   = run & acc_wgt_read;
  assign wgt_addr  = wgt_ptr;
  assign ofm_we0   = run & acc_ofm0_v;
  assign ofm_we1   = run & acc_ofm1_v;
  // Port 1 takes the slot after port 0 only when both write in the same cycle.
  assign ofm_addr0 = ofm_ptr;
  assign ofm_addr1 = ofm_we0 ? ofm_ptr + 1'b1 : ofm_ptr;
  assign ofm_inc   = {1'b0, ofm_we0} + {1'b0, ofm_we1};

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      cmd.cmd_ready <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
      acc_start     <= 1'b0;
      acc_cfg_ci    <= '0;
      acc_cfg_co    <= '0;
      tile_idx      <= '0;
      tiles_q       <= '0;
      ifm_base_q    <= '0;
      wgt_base_q    <= '0;
      ofm_base_q    <= '0;
      ifm_ptr       <= '0;
      wgt_ptr       <= '0;
      ofm_ptr       <= '0;
      wd_cnt        <= '0;
`ifdef SCHED_PERF_EN
      perf_cycles   <= '0;
`endif
    end else begin
      acc_start <= 1'b0;
      done      <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cmd.cmd_valid && cmd.cmd_ready) begin
            tiles_q       <= cmd.cmd_tiles;
            acc_cfg_ci    <= cmd.cmd_ci;
            acc_cfg_co    <= cmd.cmd_co;
            ifm_base_q    <= cmd.cmd_ifm_base;
            wgt_base_q    <= cmd.cmd_wgt_base;
            ofm_base_q    <= cmd.cmd_ofm_base;
            err           <= 1'b0;
            cmd.cmd_ready <= 1'b0;
            busy          <= 1'b1;
`ifdef SCHED_PERF_EN
            perf_cycles   <= '0;
`endif
            state         <= S_LOAD;
          end else begin
            cmd.cmd_ready <= 1'b1;
          end
        end
        S_LOAD: begin
          ifm_ptr  <= ifm_base_q;
          ofm_ptr  <= ofm_base_q;
          tile_idx <= '0;
          if (tiles_q == '0) begin
            err   <= 1'b1;
            done  <= 1'b1;
            state <= S_DONE;
          end else begin
            acc_start <= 1'b1;
            state     <= S_START;
          end
        end
        S_START: begin
          wgt_ptr <= wgt_base_q;
          wd_cnt  <= '0;
          state   <= S_RUN;
        end
        S_RUN: begin
          if (acc_ifm_read) ifm_ptr <= ifm_ptr + 1'b1;
          if (acc_wgt_read) wgt_ptr <= wgt_ptr + 1'b1;
          ofm_ptr <= ofm_ptr + OFM_AW'(ofm_inc);
`ifdef SCHED_PERF_EN
          if (perf_cycles != '1) perf_cycles <= perf_cycles + 1'b1;
`endif
          if (acc_end) begin
            if (tile_idx == tiles_q - 1'b1) begin
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              tile_idx  <= tile_idx + 1'b1;
              acc_start <= 1'b1;
              state     <= S_START;
            end
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
            // Reaching the all-ones count means the tile has hung.
            if (wd_cnt == WD_MAX - 1'b1) begin
              err   <= 1'b1;
              done  <= 1'b1;
              state <= S_DONE;
            end
          end
        end
        S_DONE: begin
          busy          <= 1'b0;
          cmd.cmd_ready <= 1'b1;
          state         <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_tile_sched.sv
// Self-checking bench for conv_tile_sched; short watchdog (TO_W=4) so timeouts are quick to reach.
module tb_conv_tile_sched;
  localparam int IFM_AW = 12;
  localparam int WGT_AW = 10;
  localparam int OFM_AW = 12;
  localparam int TILE_W = 4;
  localparam int TO_W   = 4;

  logic clk, rst;
  logic acc_start, acc_ifm_read, acc_wgt_read, acc_ofm0_v, acc_ofm1_v, acc_end;
  logic [1:0] acc_cfg_ci, acc_cfg_co;
  logic ifm_ren, wgt_ren, ofm_we0, ofm_we1, busy, done, err;
  logic [IFM_AW-1:0] ifm_addr;
  logic [WGT_AW-1:0] wgt_addr;
  logic [OFM_AW-1:0] ofm_addr0, ofm_addr1;
  logic [TILE_W-1:0] tile_idx;
`ifdef SCHED_PERF_EN
  logic [31:0] perf_cycles;
`endif

  int total = 0;
  int bad = 0;
  int start_total = 0;

  logic [IFM_AW-1:0] ifm_q[$];
  logic [WGT_AW-1:0] wgt_q[$];
  logic [OFM_AW-1:0] ofm0_q[$];
  logic [OFM_AW-1:0] ofm1_q[$];

  conv_tile_sched_if #(.IFM_AW(IFM_AW), .WGT_AW(WGT_AW), .OFM_AW(OFM_AW), .TILE_W(TILE_W)) cmd_bus ();

  conv_tile_sched #(.IFM_AW(IFM_AW), .WGT_AW(WGT_AW), .OFM_AW(OFM_AW), .TILE_W(TILE_W), .TO_W(TO_W)) dut (
    .clk(clk), .rst(rst), .cmd(cmd_bus.slave),
    .acc_start(acc_start), .acc_cfg_ci(acc_cfg_ci), .acc_cfg_co(acc_cfg_co),
    .acc_ifm_read(acc_ifm_read), .acc_wgt_read(acc_wgt_read),
    .acc_ofm0_v(acc_ofm0_v), .acc_ofm1_v(acc_ofm1_v), .acc_end(acc_end),
    .ifm_ren(ifm_ren), .ifm_addr(ifm_addr), .wgt_ren(wgt_ren), .wgt_addr(wgt_addr),
    .ofm_we0(ofm_we0), .ofm_addr0(ofm_addr0), .ofm_we1(ofm_we1), .ofm_addr1(ofm_addr1),
    .busy(busy), .done(done), .err(err), .tile_idx(tile_idx)
`ifdef SCHED_PERF_EN
    , .perf_cycles(perf_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (acc_start === 1'b1) start_total++;

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  task automatic send_cmd(input logic [TILE_W-1:0] tiles, input logic [1:0] ci, input logic [1:0] co,
                          input logic [IFM_AW-1:0] ifm, input logic [WGT_AW-1:0] wgt, input logic [OFM_AW-1:0] ofm);
    cmd_bus.cmd_tiles = tiles;
    cmd_bus.cmd_ci = ci;
    cmd_bus.cmd_co = co;
    cmd_bus.cmd_ifm_base = ifm;
    cmd_bus.cmd_wgt_base = wgt;
    cmd_bus.cmd_ofm_base = ofm;
    cmd_bus.cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_start(output bit found);
    found = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (acc_start === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({cmd_bus.cmd_ready, busy, done, err, acc_start, acc_cfg_ci, acc_cfg_co, tile_idx, ifm_ren, ifm_addr,
         wgt_ren, wgt_addr, ofm_we0, ofm_addr0, ofm_we1, ofm_addr1} !== '0) begin
      bad++;
      $display("FAIL reset_outputs ready=%b busy=%b done=%b err=%b start=%b tile=%h ifm=%h wgt=%h o0=%h o1=%h want all 0",
               cmd_bus.cmd_ready, busy, done, err, acc_start, tile_idx, ifm_addr, wgt_addr, ofm_addr0, ofm_addr1);
    end
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    total++;
    if (cmd_bus.cmd_ready !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_release ready=%b busy=%b want 1 0", cmd_bus.cmd_ready, busy);
    end
  endtask

  task automatic test_single_tile();
    logic [IFM_AW-1:0] exp_a;
    send_cmd(4'd1, 2'd2, 2'd1, 12'h100, 10'h20, 12'h000);
    total++;
    if (acc_cfg_ci !== 2'd2 || acc_cfg_co !== 2'd1 || acc_start !== 1'b0 || busy !== 1'b1 || cmd_bus.cmd_ready !== 1'b0) begin
      bad++;
      $display("FAIL single_accept ci=%0d co=%0d start=%b busy=%b ready=%b want 2 1 0 1 0",
               acc_cfg_ci, acc_cfg_co, acc_start, busy, cmd_bus.cmd_ready);
    end
    @(posedge clk); #1;
    total++;
    if (acc_start !== 1'b1) begin
      bad++;
      $display("FAIL single_start_pulse start=%b want 1", acc_start);
    end
    @(posedge clk); #1;
    total++;
    if (acc_start !== 1'b0) begin
      bad++;
      $display("FAIL single_start_width start=%b want 0", acc_start);
    end
    for (int i = 0; i < 5; i++) begin
      acc_ifm_read = 1'b1;
      ifm_q.push_back(12'h100 + 12'(i));
      @(negedge clk);
      exp_a = ifm_q.pop_front();
      total++;
      if (ifm_ren !== 1'b1 || ifm_addr !== exp_a) begin
        bad++;
        $display("FAIL single_ifm_addr i=%0d ren=%b addr=%h want 1 %h", i, ifm_ren, ifm_addr, exp_a);
      end
      @(posedge clk); #1;
    end
    acc_ifm_read = 1'b0;
    acc_end = 1'b1;
    @(posedge clk); #1;
    acc_end = 1'b0;
    total++;
    if (done !== 1'b1 || err !== 1'b0 || acc_cfg_ci !== 2'd2 || acc_cfg_co !== 2'd1) begin
      bad++;
      $display("FAIL single_done done=%b err=%b ci=%0d co=%0d want 1 0 2 1", done, err, acc_cfg_ci, acc_cfg_co);
    end
    @(posedge clk); #1;
    total++;
    if (done !== 1'b0 || busy !== 1'b0 || cmd_bus.cmd_ready !== 1'b1) begin
      bad++;
      $display("FAIL single_idle done=%b busy=%b ready=%b want 0 0 1", done, busy, cmd_bus.cmd_ready);
    end
  endtask

  task automatic test_multi_tile();
    bit found;
    int sb;
    logic [IFM_AW-1:0] m_ifm, exp_i;
    logic [WGT_AW-1:0] exp_w;
    sb = start_total;
    m_ifm = 12'h200;
    send_cmd(4'd3, 2'd1, 2'd3, 12'h200, 10'h20, 12'h000);
    for (int t = 0; t < 3; t++) begin
      wait_start(found);
      total++;
      if (!found || tile_idx !== 4'(t)) begin
        bad++;
        $display("FAIL multi_start t=%0d found=%0b tile_idx=%0d want 1 %0d", t, found, tile_idx, t);
      end
      @(posedge clk); #1;
      for (int i = 0; i < 4; i++) begin
        acc_wgt_read = 1'b1;
        wgt_q.push_back(10'h20 + 10'(i));
        acc_ifm_read = (i == 0);
        if (i == 0) begin
          ifm_q.push_back(m_ifm);
          m_ifm = m_ifm + 1'b1;
        end
        @(negedge clk);
        exp_w = wgt_q.pop_front();
        total++;
        if (wgt_ren !== 1'b1 || wgt_addr !== exp_w) begin
          bad++;
          $display("FAIL multi_wgt_addr t=%0d i=%0d ren=%b addr=%h want 1 %h", t, i, wgt_ren, wgt_addr, exp_w);
        end
        if (i == 0) begin
          exp_i = ifm_q.pop_front();
          total++;
          if (ifm_ren !== 1'b1 || ifm_addr !== exp_i) begin
            bad++;
            $display("FAIL multi_ifm_contig t=%0d ren=%b addr=%h want 1 %h", t, ifm_ren, ifm_addr, exp_i);
          end
        end
        @(posedge clk); #1;
      end
      acc_wgt_read = 1'b0;
      acc_ifm_read = 1'b0;
      acc_end = 1'b1;
      @(posedge clk); #1;
      acc_end = 1'b0;
    end
    total++;
    if (done !== 1'b1 || err !== 1'b0 || (start_total - sb) != 3) begin
      bad++;
      $display("FAIL multi_done done=%b err=%b starts=%0d want 1 0 3", done, err, start_total - sb);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_ofm_wrap();
    logic [OFM_AW-1:0] m, e0, e1;
    logic [2:0] pat [4];
    pat[0] = 3'b110; pat[1] = 3'b010; pat[2] = 3'b100; pat[3] = 3'b111;
    send_cmd(4'd1, 2'd0, 2'd0, 12'h000, 10'h000, 12'hFFE);
    acc_ofm0_v = 1'b1;
    acc_ifm_read = 1'b1;
    @(negedge clk);
    total++;
    if (ofm_we0 !== 1'b0 || ifm_ren !== 1'b0) begin
      bad++;
      $display("FAIL ofm_ignore_load we0=%b ren=%b want 0 0", ofm_we0, ifm_ren);
    end
    @(posedge clk); #1;
    @(negedge clk);
    total++;
    if (ofm_we0 !== 1'b0 || ifm_ren !== 1'b0 || acc_start !== 1'b1) begin
      bad++;
      $display("FAIL ofm_ignore_start we0=%b ren=%b start=%b want 0 0 1", ofm_we0, ifm_ren, acc_start);
    end
    @(posedge clk); #1;
    acc_ifm_read = 1'b0;
    m = 12'hFFE;
    for (int p = 0; p < 4; p++) begin
      acc_ofm0_v = pat[p][2];
      acc_ofm1_v = pat[p][1];
      acc_end    = pat[p][0];
      if (pat[p][2]) begin ofm0_q.push_back(m); m = m + 1'b1; end
      if (pat[p][1]) begin ofm1_q.push_back(m); m = m + 1'b1; end
      @(negedge clk);
      total++;
      if (ofm_we0 !== pat[p][2] || ofm_we1 !== pat[p][1]) begin
        bad++;
        $display("FAIL ofm_we p=%0d we0=%b we1=%b want %b %b", p, ofm_we0, ofm_we1, pat[p][2], pat[p][1]);
      end
      if (pat[p][2]) begin
        e0 = ofm0_q.pop_front();
        total++;
        if (ofm_addr0 !== e0) begin
          bad++;
          $display("FAIL ofm_addr0 p=%0d addr=%h want %h", p, ofm_addr0, e0);
        end
      end
      if (pat[p][1]) begin
        e1 = ofm1_q.pop_front();
        total++;
        if (ofm_addr1 !== e1) begin
          bad++;
          $display("FAIL ofm_addr1 p=%0d addr=%h want %h", p, ofm_addr1, e1);
        end
      end
      @(posedge clk); #1;
    end
    acc_ofm0_v = 1'b0;
    acc_ofm1_v = 1'b0;
    acc_end = 1'b0;
    total++;
    if (done !== 1'b1 || err !== 1'b0) begin
      bad++;
      $display("FAIL ofm_done done=%b err=%b want 1 0", done, err);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_errors();
    bit found;
    int sb;
    sb = start_total;
    send_cmd(4'd0, 2'd1, 2'd1, 12'h000, 10'h000, 12'h000);
    @(posedge clk); #1;
    total++;
    if (done !== 1'b1 || err !== 1'b1) begin
      bad++;
      $display("FAIL zero_tiles done=%b err=%b want 1 1", done, err);
    end
    @(posedge clk); #1;
    total++;
    if (done !== 1'b0 || err !== 1'b1 || cmd_bus.cmd_ready !== 1'b1 || (start_total - sb) != 0) begin
      bad++;
      $display("FAIL zero_tiles_after done=%b err=%b ready=%b starts=%0d want 0 1 1 0",
               done, err, cmd_bus.cmd_ready, start_total - sb);
    end
    send_cmd(4'd2, 2'd0, 2'd0, 12'h000, 10'h000, 12'h000);
    total++;
    if (err !== 1'b0) begin
      bad++;
      $display("FAIL err_clear_on_accept err=%b want 0", err);
    end
    wait_start(found);
    total++;
    if (!found) begin
      bad++;
      $display("FAIL wd_start found=%0b want 1", found);
    end
    @(posedge clk); #1;
    repeat (14) @(posedge clk);
    #1;
    total++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL wd_early done=%b busy=%b want 0 1", done, busy);
    end
    @(posedge clk); #1;
    total++;
    if (done !== 1'b1 || err !== 1'b1 || tile_idx !== 4'd0) begin
      bad++;
      $display("FAIL wd_timeout done=%b err=%b tile=%0d want 1 1 0", done, err, tile_idx);
    end
    @(posedge clk); #1;
    total++;
    if (busy !== 1'b0 || cmd_bus.cmd_ready !== 1'b1 || err !== 1'b1) begin
      bad++;
      $display("FAIL wd_idle busy=%b ready=%b err=%b want 0 1 1", busy, cmd_bus.cmd_ready, err);
    end
  endtask

  task automatic test_rst_abort();
    bit found;
    logic [IFM_AW-1:0] exp_a;
    send_cmd(4'd3, 2'd3, 2'd2, 12'h300, 10'h010, 12'h080);
    wait_start(found);
    @(posedge clk); #1;
    acc_end = 1'b1;
    @(posedge clk); #1;
    acc_end = 1'b0;
    wait_start(found);
    total++;
    if (!found || tile_idx !== 4'd1) begin
      bad++;
      $display("FAIL abort_tile1 found=%0b tile=%0d want 1 1", found, tile_idx);
    end
    @(posedge clk); #1;
    acc_ifm_read = 1'b1;
    acc_wgt_read = 1'b1;
    acc_ofm0_v = 1'b1;
    ifm_q.push_back(12'h300);
    @(negedge clk);
    exp_a = ifm_q.pop_front();
    total++;
    if (ifm_ren !== 1'b1 || ifm_addr !== exp_a) begin
      bad++;
      $display("FAIL abort_pre_ifm ren=%b addr=%h want 1 %h", ifm_ren, ifm_addr, exp_a);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    total++;
    if (busy !== 1'b0 || ifm_ren !== 1'b0 || wgt_ren !== 1'b0 || ofm_we0 !== 1'b0 || tile_idx !== 4'd0) begin
      bad++;
      $display("FAIL abort_idle busy=%b ren=%b%b we0=%b tile=%0d want 0 00 0 0",
               busy, ifm_ren, wgt_ren, ofm_we0, tile_idx);
    end
    acc_end = 1'b1;
    acc_ofm1_v = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      total++;
      if (ifm_ren !== 1'b0 || wgt_ren !== 1'b0 || ofm_we0 !== 1'b0 || ofm_we1 !== 1'b0 ||
          acc_start !== 1'b0 || done !== 1'b0 || ifm_addr !== 12'h000) begin
        bad++;
        $display("FAIL abort_quiet k=%0d ren=%b%b we=%b%b start=%b done=%b ifm=%h want all 0",
                 k, ifm_ren, wgt_ren, ofm_we0, ofm_we1, acc_start, done, ifm_addr);
      end
      @(posedge clk); #1;
    end
    acc_ifm_read = 1'b0;
    acc_wgt_read = 1'b0;
    acc_ofm0_v = 1'b0;
    acc_ofm1_v = 1'b0;
    acc_end = 1'b0;
    total++;
    if (cmd_bus.cmd_ready !== 1'b1) begin
      bad++;
      $display("FAIL abort_ready ready=%b want 1", cmd_bus.cmd_ready);
    end
  endtask

  task automatic test_back_to_back();
    bit found;
    logic [WGT_AW-1:0] exp_w;
    for (int c = 0; c < 2; c++) begin
      send_cmd(4'd1, 2'(c), 2'(3 - c), 12'h040, 10'h3FE + 10'(c), 12'h000);
      wait_start(found);
      @(posedge clk); #1;
      acc_wgt_read = 1'b1;
      for (int i = 0; i < 3; i++) begin
        wgt_q.push_back(10'h3FE + 10'(c) + 10'(i));
        @(negedge clk);
        exp_w = wgt_q.pop_front();
        total++;
        if (!found || wgt_ren !== 1'b1 || wgt_addr !== exp_w) begin
          bad++;
          $display("FAIL b2b_wgt c=%0d i=%0d found=%0b ren=%b addr=%h want 1 1 %h", c, i, found, wgt_ren, wgt_addr, exp_w);
        end
        @(posedge clk); #1;
      end
      acc_wgt_read = 1'b0;
      acc_end = 1'b1;
      @(posedge clk); #1;
      acc_end = 1'b0;
      total++;
      if (done !== 1'b1 || acc_cfg_ci !== 2'(c) || acc_cfg_co !== 2'(3 - c)) begin
        bad++;
        $display("FAIL b2b_done c=%0d done=%b ci=%0d co=%0d want 1 %0d %0d", c, done, acc_cfg_ci, acc_cfg_co, c, 3 - c);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    rst = 1'b1;
    acc_ifm_read = 1'b0;
    acc_wgt_read = 1'b0;
    acc_ofm0_v = 1'b0;
    acc_ofm1_v = 1'b0;
    acc_end = 1'b0;
    cmd_bus.cmd_valid = 1'b0;
    cmd_bus.cmd_tiles = '0;
    cmd_bus.cmd_ci = '0;
    cmd_bus.cmd_co = '0;
    cmd_bus.cmd_ifm_base = '0;
    cmd_bus.cmd_wgt_base = '0;
    cmd_bus.cmd_ofm_base = '0;
    test_reset();
    test_single_tile();
    test_multi_tile();
    test_ofm_wrap();
    test_errors();
    test_rst_abort();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
